// File: rtl/data_unpacker.sv
// Width down-converter: accepts a wide word plus a beat count from a FIFO read
// port and replays that many narrow slices, least-significant slice first,
// marking the final slice. A new word is taken in the same cycle the previous
// word's last beat is accepted, so back-to-back words stream without bubbles.
module data_unpacker #(
  parameter int unsigned NarrowWidth = 8,
  parameter int unsigned Ratio       = 4
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NarrowWidth*Ratio-1:0]  wide_data_i,
  input  logic [$clog2(Ratio+1)-1:0]    wide_count_i,
  input  logic                          wide_valid_i,
  output logic                          wide_ready_o,
  output logic [NarrowWidth-1:0]        narrow_data_o,
  output logic                          narrow_last_o,
  output logic                          narrow_valid_o,
  input  logic                          narrow_ready_i,
  output logic                          busy_o
);

  localparam int unsigned CW = $clog2(Ratio + 1);
  localparam int unsigned IW = $clog2(Ratio);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                               state_q, state_d;
  logic [Ratio-1:0][NarrowWidth-1:0]    hold_q;
  logic [CW-1:0]                        cnt_q;
  logic [IW-1:0]                        idx_q;
  logic [CW-1:0]                        n_eff;
  logic                                 last_beat;
  logic                                 wide_hs;
  logic                                 narrow_hs;
  logic                                 load;

  // Counts above Ratio are clamped rather than flagged.
  assign n_eff     = (wide_count_i > CW'(Ratio)) ? CW'(Ratio) : wide_count_i;
  // Only meaningful in SEND, where cnt_q is at least 1.
  assign last_beat = (CW'(idx_q) == (cnt_q - CW'(1)));
  assign wide_hs   = wide_valid_i & wide_ready_o;
  assign narrow_hs = narrow_valid_o & narrow_ready_i;
  // Zero-beat words are consumed without touching the hold register.
  assign load      = wide_hs & (n_eff != '0);

  // State register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a word accept decides the state outright; otherwise leave
  // SEND once the last beat is taken.
  always_comb begin
    state_d = state_q;
    if (wide_hs)                     state_d = (n_eff != '0) ? SEND : IDLE;
    else if (narrow_hs && last_beat) state_d = IDLE;
  end

  // Outputs. wide_ready_o looks through narrow_ready_i so the next word can be
  // taken in the last-beat cycle; there is no path from wide_data_i.
  always_comb begin
    narrow_valid_o = 1'b0;
    narrow_last_o  = 1'b0;
    busy_o         = 1'b0;
    wide_ready_o   = 1'b1;
    narrow_data_o  = hold_q[idx_q];
    if (state_q == SEND) begin
      narrow_valid_o = 1'b1;
      narrow_last_o  = last_beat;
      busy_o         = 1'b1;
      wide_ready_o   = narrow_ready_i & last_beat;
    end
  end

  // Hold register, beat total and beat index; idx only advances on a
  // non-final accepted beat, so it never passes cnt-1.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      hold_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else if (load) begin
      hold_q <= wide_data_i;
      cnt_q  <= n_eff;
      idx_q  <= '0;
    end else if (narrow_hs && !last_beat) begin
      idx_q  <= idx_q + IW'(1);
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Bench for data_unpacker (NarrowWidth=8, Ratio=4): directed scenarios with
// fixed expected beats, then random traffic against a queue model holding the
// beats still owed for the current word.
module tb_data_unpacker;

  localparam int NW = 8;
  localparam int R  = 4;
  localparam int W  = NW * R;
  localparam int CW = $clog2(R + 1);

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic [W-1:0]  wide_data_i;
  logic [CW-1:0] wide_count_i;
  logic          wide_valid_i;
  logic          wide_ready_o;
  logic [NW-1:0] narrow_data_o;
  logic          narrow_last_o;
  logic          narrow_valid_o;
  logic          narrow_ready_i;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  data_unpacker #(.NarrowWidth(NW), .Ratio(R)) dut (
    .clk_i          (clk_i),
    .arst_ni        (arst_ni),
    .wide_data_i    (wide_data_i),
    .wide_count_i   (wide_count_i),
    .wide_valid_i   (wide_valid_i),
    .wide_ready_o   (wide_ready_o),
    .narrow_data_o  (narrow_data_o),
    .narrow_last_o  (narrow_last_o),
    .narrow_valid_o (narrow_valid_o),
    .narrow_ready_i (narrow_ready_i),
    .busy_o         (busy_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  // Count accepted narrow beats on each clock edge.
  always @(posedge clk_i) if (narrow_valid_o && narrow_ready_i) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [CW-1:0] c,
                       input logic r);
    wide_valid_i   = v;
    wide_data_i    = d;
    wide_count_i   = c;
    narrow_ready_i = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_vld"},  32'(narrow_valid_o), 32'd1);
    chk({tag, "_data"}, 32'(narrow_data_o),  32'(d));
    chk({tag, "_last"}, 32'(narrow_last_o),  32'(l));
    chk({tag, "_busy"}, 32'(busy_o),         32'd1);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_vld"},  32'(narrow_valid_o), 32'd0);
    chk({tag, "_last"}, 32'(narrow_last_o),  32'd0);
    chk({tag, "_busy"}, 32'(busy_o),         32'd0);
  endtask

  initial begin
    logic [7:0]    q[$];
    logic          v, r, ev, ewr;
    logic [W-1:0]  d;
    logic [CW-1:0] c;
    int            h0, nb;

    // Reset values.
    arst_ni = 1'b0;
    drive(0, '0, '0, 0);
    #8;
    idle_chk("rst");
    chk("rst_data", 32'(narrow_data_o), 32'd0);
    chk("rst_wrdy", 32'(wide_ready_o), 32'd1);
    arst_ni = 1'b1;
    tick();

    // Single full word.
    drive(1, 32'hDDCCBBAA, 4, 1);
    chk("t1_wrdy_idle", 32'(wide_ready_o), 32'd1);
    idle_chk("t1_pre");
    tick();
    drive(0, '0, 0, 1);
    beat("t1_b0", 8'hAA, 0); chk("t1_wrdy_b0", 32'(wide_ready_o), 32'd0); tick();
    beat("t1_b1", 8'hBB, 0); tick();
    beat("t1_b2", 8'hCC, 0); tick();
    beat("t1_b3", 8'hDD, 1); chk("t1_wrdy_b3", 32'(wide_ready_o), 32'd1); tick();
    idle_chk("t1_post");

    // Back-to-back words, no bubble.
    drive(1, 32'h44332211, 4, 1); tick();
    drive(1, 32'h000000EE, 1, 1);
    beat("t2_b0", 8'h11, 0); chk("t2_wrdy_b0", 32'(wide_ready_o), 32'd0); tick();
    beat("t2_b1", 8'h22, 0); tick();
    beat("t2_b2", 8'h33, 0); tick();
    beat("t2_b3", 8'h44, 1); chk("t2_wrdy_b3", 32'(wide_ready_o), 32'd1); tick();
    drive(0, '0, 0, 1);
    beat("t2_ee", 8'hEE, 1); tick();
    idle_chk("t2_post");

    // Backpressure, ready pattern 1,0,0,1,1.
    drive(1, 32'h99CCBBAA, 3, 1); tick();
    h0 = hs_cnt;
    drive(0, '0, 0, 1); beat("t3_c0", 8'hAA, 0); chk("t3_wrdy_c0", 32'(wide_ready_o), 32'd0); tick();
    drive(0, '0, 0, 0); beat("t3_c1", 8'hBB, 0); chk("t3_wrdy_c1", 32'(wide_ready_o), 32'd0); tick();
    beat("t3_c2", 8'hBB, 0); chk("t3_wrdy_c2", 32'(wide_ready_o), 32'd0); tick();
    drive(0, '0, 0, 1); beat("t3_c3", 8'hBB, 0); chk("t3_wrdy_c3", 32'(wide_ready_o), 32'd0); tick();
    beat("t3_c4", 8'hCC, 1); chk("t3_wrdy_c4", 32'(wide_ready_o), 32'd1); tick();
    idle_chk("t3_post");
    chk("t3_nbeats", 32'(hs_cnt - h0), 32'd3);

    // Count 0: consumed, nothing emitted.
    drive(1, 32'h12345678, 0, 1);
    chk("t4_wrdy", 32'(wide_ready_o), 32'd1); tick();
    drive(0, '0, 0, 1); idle_chk("t4_a"); tick();
    idle_chk("t4_b");

    // Count 7 clamps to 4.
    drive(1, 32'h87654321, 7, 1); tick();
    drive(0, '0, 0, 1);
    beat("t5_b0", 8'h21, 0); tick();
    beat("t5_b1", 8'h43, 0); tick();
    beat("t5_b2", 8'h65, 0); tick();
    beat("t5_b3", 8'h87, 1); tick();
    idle_chk("t5_post");

    // Count 1.
    drive(1, 32'h3F3F3F5A, 1, 1); tick();
    drive(0, '0, 0, 1);
    beat("t6_b0", 8'h5A, 1); tick();
    idle_chk("t6_post");

    // Reset mid-word after beat 0 has been taken.
    drive(1, 32'h0D0C0B0A, 4, 1); tick();
    drive(0, '0, 0, 1);
    beat("t7_b0", 8'h0A, 0); tick();
    beat("t7_b1", 8'h0B, 0);
    #2 arst_ni = 1'b0;
    #1;
    idle_chk("t7_rst");
    chk("t7_rst_wrdy", 32'(wide_ready_o), 32'd1);
    tick(); tick();
    arst_ni = 1'b1;
    drive(1, 32'h44332211, 4, 1);
    idle_chk("t7_rel");
    tick();
    drive(0, '0, 0, 1);
    beat("t7_n0", 8'h11, 0); tick();
    beat("t7_n1", 8'h22, 0); tick();
    beat("t7_n2", 8'h33, 0); tick();
    beat("t7_n3", 8'h44, 1); tick();

    // Random traffic against the beat-queue model.
    q.delete();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      d = $urandom;
      c = CW'($urandom_range(0, 7));
      drive(v, d, c, r);
      ev  = (q.size() != 0);
      ewr = (q.size() == 0) || (q.size() == 1 && r);
      chk("rnd_vld",  32'(narrow_valid_o), 32'(ev));
      chk("rnd_busy", 32'(busy_o),         32'(ev));
      chk("rnd_wrdy", 32'(wide_ready_o),   32'(ewr));
      if (ev) begin
        chk("rnd_data", 32'(narrow_data_o), 32'(q[0]));
        chk("rnd_last", 32'(narrow_last_o), 32'(q.size() == 1));
      end
      if (ev && r) void'(q.pop_front());
      if (v && ewr) begin
        nb = (int'(c) > R) ? R : int'(c);
        for (int k = 0; k < nb; k++) q.push_back(d[k*NW +: NW]);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
